ysyx_22040386_mem_arbiter: RTL

//  Shares the single physical memory port between the instruction fetch (IFU) and load/store (MEMU) paths.

---
 rtl/ysyx_22040386_pkg.sv | 19 +
 rtl/ysyx_22040386_arb_pick.sv | 38 +++
 rtl/ysyx_22040386_mem_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/ysyx_22040386_pkg.sv
// Shared types and defaults for the memory-port arbiter.
// Holds the arbiter state encoding, owner codes and bus-width defaults.
package ysyx_22040386_pkg;

    localparam int AW_DEF         = 64;
    localparam int DW_DEF         = 64;
    localparam int STARVE_LIM_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_IFU  = 2'b01;
    localparam logic [1:0] OWN_LSU  = 2'b10;

endpackage

// File: rtl/ysyx_22040386_arb_pick.sv
// Priority select between IFU and LSU: LSU wins unless IFU has been passed over
// STARVE_LIM times in a row, in which case IFU takes the next grant.
module ysyx_22040386_arb_pick #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ifu_valid,
    input  logic lsu_valid,
    output logic ifu_grant,
    output logic lsu_grant
);

    localparam int CW = $clog2(STARVE_LIM + 2);

    logic [CW-1:0] starve_cnt;
    logic          ifu_turn;

    assign ifu_turn  = ifu_valid && (!lsu_valid || starve_cnt == CW'(STARVE_LIM));
    assign ifu_grant = en && ifu_turn;
    assign lsu_grant = en && lsu_valid && !ifu_turn;

    // Counts LSU wins that left a waiting IFU behind; any other grant clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (ifu_grant) begin
            starve_cnt <= '0;
        end else if (lsu_grant) begin
            if (!ifu_valid)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_LIM))
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one memory port between fetch (IFU) and load/store (LSU), one
// transaction in flight at a time: IDLE accepts, ISSUE presents, WAIT returns.
module ysyx_22040386_mem_arbiter
    import ysyx_22040386_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_req_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_resp_data,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic            lsu_req_wen,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic [DW/8-1:0] lsu_req_wmask,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_resp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_resp_data,
    output logic [1:0]      arb_owner
);

    arb_state_e state, state_nxt;
    logic [1:0] owner;
    logic       ifu_hs, lsu_hs, in_wait;

    ysyx_22040386_arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ARB_IDLE && !rst),
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .ifu_grant (ifu_req_ready),
        .lsu_grant (lsu_req_ready)
    );

    assign ifu_hs = ifu_req_valid && ifu_req_ready;
    assign lsu_hs = lsu_req_valid && lsu_req_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (ifu_hs || lsu_hs) state_nxt = ARB_ISSUE;
            ARB_ISSUE: if (mem_req_ready)    state_nxt = ARB_WAIT;
            ARB_WAIT:  if (mem_resp_valid)   state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            owner         <= OWN_NONE;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            state <= state_nxt;
            if (ifu_hs) begin
                owner         <= OWN_IFU;
                mem_req_addr  <= ifu_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wmask <= '0;
            end else if (lsu_hs) begin
                owner         <= OWN_LSU;
                mem_req_addr  <= lsu_req_addr;
                mem_req_wen   <= lsu_req_wen;
                mem_req_wdata <= lsu_req_wdata;
                mem_req_wmask <= lsu_req_wmask;
            end else if (state == ARB_WAIT && mem_resp_valid) begin
                owner <= OWN_NONE;
            end
        end
    end

    assign mem_req_valid = (state == ARB_ISSUE);
    assign arb_owner     = owner;

    // Responses outside WAIT, or while reset is asserted, never reach a requester.
    assign in_wait        = (state == ARB_WAIT) && !rst && mem_resp_valid;
    assign ifu_resp_valid = in_wait && owner == OWN_IFU;
    assign lsu_resp_valid = in_wait && owner == OWN_LSU;
    assign ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
    assign lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;

    a_ifu_hold: assert property (@(posedge clk) disable iff (rst)
        ifu_req_valid && !ifu_req_ready |=> ifu_req_valid);
    a_lsu_hold: assert property (@(posedge clk) disable iff (rst)
        lsu_req_valid && !lsu_req_ready |=> lsu_req_valid);

endmodule
